spi_slave_port: RTL and testbench
=================================

Name: spi_slave_port

Overview:
- SPI responder (slave end) for the processor's SPI master interface: pins sclk, mosi, miso, cs.
- Receives MOSI bytes into a small RX FIFO and returns bytes from a one-entry TX holding register on MISO.
- Used as the companion peripheral / bench-side endpoint of the processor's SPI I/O instructions.
- Fully synchronous to the system clock; SPI pins are oversampled, not used as clocks.

Parameters:
- DATA_W, 8, frame width in bits; must equal DATAPATH_W.
- FIFO_DEPTH, 4, RX FIFO entries; power of two, at least 2.
- SYNC_STAGES, 2, synchronizer flops on sclk_in, cs_n_in and mosi_in; at least 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- sclk_in  in  1  SPI clock from master; idle low (mode 0).
- cs_n_in  in  1  chip select, active low.
- mosi_in  in  1  master-out data.
- miso_out  out  1  slave-out data.
- miso_oe_out  out  1  high while selected (synchronized cs low).
- rx_data_out  out  DATA_W  head of RX FIFO.
- rx_valid_out  out  1  RX FIFO not empty.
- rx_ready_in  in  1  pop RX FIFO when valid & ready.
- tx_data_in  in  DATA_W  byte to return on next frame.
- tx_valid_in  in  1  load TX holding register.
- tx_ready_out  out  1  TX holding register empty.
- rx_overflow_out  out  1  one-cycle pulse: received byte dropped because FIFO full.
- busy_out  out  1  frame in progress (state SHIFT).

Behaviour:
- Reset: all registers cleared.
  - miso_out=0, miso_oe_out=0, rx_valid_out=0, rx_data_out=0, tx_ready_out=1, rx_overflow_out=0, busy_out=0.
  - Bit counter=0, FIFO empty.
- Synchronizers: sclk, cs_n and mosi each pass through SYNC_STAGES flops. Edge detects compare the last two stages.
- Timing constraint: sclk high and low phases are each at least 2 clk periods. No behaviour is guaranteed when faster.
- SPI mode 0, MSB first:
  - mosi is sampled on a synchronized sclk rising edge.
  - miso changes on a synchronized sclk falling edge.
- FSM states: IDLE, SHIFT.
  - IDLE -> SHIFT on synchronized cs falling edge.
    - TX shift register <= holding register if full, else 0x00. Holding register marked empty.
    - Bit counter <= 0.
    - miso_out <= MSB of the loaded value.
  - SHIFT, on sclk rise: rx_shift <= {rx_shift[DATA_W-2:0], mosi}; bit counter += 1 (wraps at DATA_W).
    - On the DATA_W-th rise, the completed byte is pushed to the RX FIFO the next cycle.
  - SHIFT, on sclk fall:
    - Counter nonzero: tx_shift shifts left and miso_out <= new MSB.
    - Counter wrapped to 0: reload tx_shift from the holding register (or 0x00) for a back-to-back frame, same rule as frame start.
  - SHIFT -> IDLE on synchronized cs rising edge.
    - A partial byte (counter != 0) is discarded; no FIFO push.
    - The consumed TX byte is not restored.
    - miso_oe_out deasserts the same cycle.
- Latency: byte completes at pin sclk rise T; rx_valid_out is high SYNC_STAGES+2 clk cycles later (FIFO previously empty).
- RX FIFO behaviour:
  - Push while full: byte dropped, rx_overflow_out pulses for 1 cycle, FIFO contents unchanged.
  - Simultaneous push and pop while full: pop first, push accepted, no overflow.
  - rx_data_out is valid only while rx_valid_out is high; otherwise it holds its last value.
- TX holding register behaviour:
  - tx_valid_in is accepted only when tx_ready_out=1; otherwise ignored (no overwrite).
  - Load coinciding with a frame-start or wrap consume in the same cycle: the consume takes the old value (empty -> 0x00) and the new byte is stored.
- Async reset mid-frame: returns to IDLE immediately. The next frame starts only on a fresh cs falling edge after reset release.

Optional Feature:
- SPI_SLAVE_LOOPBACK_EN defined: when the TX holding register is empty at a load point, the TX shift register loads the last completed RX byte (0x00 after reset) instead of 0x00. This echoes the previous frame for bench bring-up.
- Undefined: empty holding register always sends 0x00.

Decomposition:
- Shared package/defs:
  - DATAPATH_W (reuse).
  - State encodings SPI_SLV_IDLE=1'b0, SPI_SLV_SHIFT=1'b1.
  - SPI_IDLE_BYTE=8'h00.
- One sub-module: sync_fifo (parameters DATA_W, FIFO_DEPTH; clk, rst_n, push/pop, full/empty, data in/out), used for the RX FIFO.
- Synchronizers and shift logic stay inline.

Test Plan:
- Reset then tx byte 0xA5 loaded; master sends 0x3C in one frame.
  - miso bits 1,0,1,0,0,1,0,1.
  - rx_data_out=0x3C, rx_valid_out high SYNC_STAGES+2 cycles after the 8th rise.
  - tx_ready_out=1 after cs falls.
- No tx loaded; master sends 0x81.
  - miso all zeros (loopback off).
  - With SPI_SLAVE_LOOPBACK_EN, a second frame returns 0x81.
- Five back-to-back bytes 0x01..0x05 with rx_ready_in=0, FIFO_DEPTH=4.
  - FIFO holds 0x01..0x04.
  - rx_overflow_out pulses once on byte 5.
  - Pops return 0x01..0x04 in order.
- cs raised after 5 bits of 0xFF.
  - No FIFO push, busy_out drops.
  - Next full frame 0x42 received intact.
- rst_n asserted after 3 bits of a frame.
  - All outputs return to reset values within the cycle.
  - After release, a new frame 0x99 is received correctly.
- tx_valid_in with 0x55 in the same cycle as the cs-fall consume (holding register empty).
  - Frame 1 sends 0x00; frame 2 sends 0x55.

Source files
------------

// File: rtl/spi_slave_port_pkg.sv
// Shared definitions for the SPI responder: datapath width, FSM encoding
// and the byte returned when nothing has been queued for transmission.
package spi_slave_port_pkg;

    localparam int DATAPATH_W = 8;

    typedef enum logic {
        SPI_SLV_IDLE  = 1'b0,
        SPI_SLV_SHIFT = 1'b1
    } spi_slv_state_e;

    localparam logic [DATAPATH_W-1:0] SPI_IDLE_BYTE = 8'h00;

endpackage

// File: rtl/spi_slave_port_sync_fifo.sv
// Small synchronous FIFO used as the SPI receive queue.
// FIFO_DEPTH must be a power of two (pointers wrap naturally).
// A pop and a push in the same cycle while full are both honoured.
module sync_fifo
    import spi_slave_port_pkg::*;
#(
    parameter int DATA_W     = DATAPATH_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data,
    output logic              o_full,
    output logic              o_empty
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              w_do_pop;
    logic              w_do_push;

    assign w_do_pop  = i_pop & (r_count != {(AW+1){1'b0}});
    assign w_do_push = i_push & ((r_count != DEPTH_C) | w_do_pop);

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == DEPTH_C);
    assign o_empty = (r_count == {(AW+1){1'b0}});

    // Storage array and pointer/occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= {DATA_W{1'b0}};
            end
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {(AW+1){1'b0}};
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/spi_slave_port.sv
// SPI mode-0 responder, MSB first, oversampled on the system clock.
// Received bytes go to a small RX FIFO; one holding register supplies the
// byte returned on MISO. Optional build macro SPI_SLAVE_LOOPBACK_EN makes an
// empty holding register echo the last completed RX byte instead of 0x00.
module spi_slave_port
    import spi_slave_port_pkg::*;
#(
    parameter int DATA_W      = DATAPATH_W,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk_in,
    input  logic              cs_n_in,
    input  logic              mosi_in,
    output logic              miso_out,
    output logic              miso_oe_out,
    output logic [DATA_W-1:0] rx_data_out,
    output logic              rx_valid_out,
    input  logic              rx_ready_in,
    input  logic [DATA_W-1:0] tx_data_in,
    input  logic              tx_valid_in,
    output logic              tx_ready_out,
    output logic              rx_overflow_out,
    output logic              busy_out
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DATA_W - 1);
    localparam logic [DATA_W-1:0] IDLE_BYTE = DATA_W'(SPI_IDLE_BYTE);

    // Pin synchronizers; the extra *_prev flop gives a clean edge compare.
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_prev;
    logic                   r_cs_prev;

    spi_slv_state_e r_state;
    spi_slv_state_e w_state_nxt;

    logic [CNT_W-1:0]  r_bit_cnt;
    logic [DATA_W-2:0] r_rx_shift;     // bits received so far in this frame
    logic [DATA_W-2:0] r_tx_shift;     // bits still to send after the current MSB
    logic              r_miso;
    logic              r_push_pend;
    logic [DATA_W-1:0] r_push_data;    // last completed RX byte
    logic [DATA_W-1:0] r_tx_hold;
    logic              r_tx_empty;
    logic              r_busy;
    logic              r_miso_oe;
    logic              r_rx_overflow;
    logic [DATA_W-1:0] r_rx_last;

    logic              w_sclk_rise;
    logic              w_sclk_fall;
    logic              w_cs_fall;
    logic              w_cs_rise;
    logic              w_mosi;
    logic              w_frame_start;
    logic              w_in_shift;
    logic              w_do_rise;
    logic              w_do_fall;
    logic              w_load;
    logic              w_tx_accept;
    logic [DATA_W-1:0] w_empty_byte;
    logic [DATA_W-1:0] w_load_byte;
    logic              w_fifo_pop;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [DATA_W-1:0] w_fifo_data;

    assign w_sclk_rise =  r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_prev;
    assign w_sclk_fall = ~r_sclk_sync[SYNC_STAGES-1] &  r_sclk_prev;
    assign w_cs_fall   = ~r_cs_sync[SYNC_STAGES-1]   &  r_cs_prev;
    assign w_cs_rise   =  r_cs_sync[SYNC_STAGES-1]   & ~r_cs_prev;
    assign w_mosi      =  r_mosi_sync[SYNC_STAGES-1];

    // A cs rise ends the frame even if an sclk edge is seen in the same cycle.
    assign w_frame_start = (r_state == SPI_SLV_IDLE) & w_cs_fall;
    assign w_in_shift    = (r_state == SPI_SLV_SHIFT) & ~w_cs_rise;
    assign w_do_rise     = w_in_shift & w_sclk_rise;
    assign w_do_fall     = w_in_shift & w_sclk_fall;
    assign w_load        = w_frame_start | (w_do_fall & (r_bit_cnt == {CNT_W{1'b0}}));
    assign w_tx_accept   = tx_valid_in & r_tx_empty;

`ifdef SPI_SLAVE_LOOPBACK_EN
    assign w_empty_byte = r_push_data;
`else
    assign w_empty_byte = IDLE_BYTE;
`endif

    // The consume always sees the value held before any same-cycle load.
    assign w_load_byte = r_tx_empty ? w_empty_byte : r_tx_hold;

    // Shift the raw pins through the synchronizer chains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_sync <= {SYNC_STAGES{1'b0}};
            r_cs_sync   <= {SYNC_STAGES{1'b0}};
            r_mosi_sync <= {SYNC_STAGES{1'b0}};
            r_sclk_prev <= 1'b0;
            r_cs_prev   <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk_in};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n_in};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi_in};
            r_sclk_prev <= r_sclk_sync[SYNC_STAGES-1];
            r_cs_prev   <= r_cs_sync[SYNC_STAGES-1];
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SPI_SLV_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state: select on cs fall, release on cs rise.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SPI_SLV_IDLE: begin
                if (w_cs_fall) begin
                    w_state_nxt = SPI_SLV_SHIFT;
                end else begin
                    w_state_nxt = SPI_SLV_IDLE;
                end
            end
            SPI_SLV_SHIFT: begin
                if (w_cs_rise) begin
                    w_state_nxt = SPI_SLV_IDLE;
                end else begin
                    w_state_nxt = SPI_SLV_SHIFT;
                end
            end
            default: w_state_nxt = SPI_SLV_IDLE;
        endcase
    end

    // Bit counter and RX/TX shift registers, MISO driven from the TX MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt   <= {CNT_W{1'b0}};
            r_rx_shift  <= {(DATA_W-1){1'b0}};
            r_tx_shift  <= {(DATA_W-1){1'b0}};
            r_miso      <= 1'b0;
            r_push_pend <= 1'b0;
            r_push_data <= {DATA_W{1'b0}};
        end else begin
            r_push_pend <= 1'b0;
            if (w_frame_start) begin
                r_bit_cnt  <= {CNT_W{1'b0}};
                r_tx_shift <= w_load_byte[DATA_W-2:0];
                r_miso     <= w_load_byte[DATA_W-1];
            end else if (w_do_rise) begin
                r_rx_shift <= {r_rx_shift[DATA_W-3:0], w_mosi};
                if (r_bit_cnt == CNT_LAST) begin
                    r_bit_cnt   <= {CNT_W{1'b0}};
                    r_push_pend <= 1'b1;
                    r_push_data <= {r_rx_shift, w_mosi};
                end else begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
            end else if (w_do_fall) begin
                if (r_bit_cnt == {CNT_W{1'b0}}) begin
                    r_tx_shift <= w_load_byte[DATA_W-2:0];
                    r_miso     <= w_load_byte[DATA_W-1];
                end else begin
                    r_tx_shift <= {r_tx_shift[DATA_W-3:0], 1'b0};
                    r_miso     <= r_tx_shift[DATA_W-2];
                end
            end else begin
                r_bit_cnt <= r_bit_cnt;
            end
        end
    end

    // TX holding register: accept only when empty; a load point empties it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_hold  <= {DATA_W{1'b0}};
            r_tx_empty <= 1'b1;
        end else if (w_tx_accept) begin
            r_tx_hold  <= tx_data_in;
            r_tx_empty <= 1'b0;
        end else if (w_load) begin
            r_tx_empty <= 1'b1;
        end else begin
            r_tx_empty <= r_tx_empty;
        end
    end

    // Status outputs: select indication and the overflow pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy        <= 1'b0;
            r_miso_oe     <= 1'b0;
            r_rx_overflow <= 1'b0;
        end else begin
            r_busy        <= (w_state_nxt == SPI_SLV_SHIFT);
            r_miso_oe     <= (w_state_nxt == SPI_SLV_SHIFT);
            r_rx_overflow <= r_push_pend & w_fifo_full & ~w_fifo_pop;
        end
    end

    // Remember the FIFO head so rx_data_out holds its value once drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_last <= {DATA_W{1'b0}};
        end else if (!w_fifo_empty) begin
            r_rx_last <= w_fifo_data;
        end else begin
            r_rx_last <= r_rx_last;
        end
    end

    assign w_fifo_pop = rx_ready_in & ~w_fifo_empty;

    sync_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_push_pend),
        .i_pop   (w_fifo_pop),
        .i_data  (r_push_data),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign miso_out        = r_miso;
    assign miso_oe_out     = r_miso_oe;
    assign busy_out        = r_busy;
    assign rx_overflow_out = r_rx_overflow;
    assign tx_ready_out    = r_tx_empty;
    assign rx_valid_out    = ~w_fifo_empty;
    assign rx_data_out     = w_fifo_empty ? r_rx_last : w_fifo_data;

endmodule

// File: tb/tb_spi_slave_port.sv
// Self-checking bench for spi_slave_port: a behavioural SPI master drives
// frames, expected RX bytes are queued as frames complete and compared when
// the DUT presents them.
module tb_spi_slave_port;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int SS    = 2;

    logic          clk;
    logic          rst_n;
    logic          sclk_in;
    logic          cs_n_in;
    logic          mosi_in;
    logic          miso_out;
    logic          miso_oe_out;
    logic [DW-1:0] rx_data_out;
    logic          rx_valid_out;
    logic          rx_ready_in;
    logic [DW-1:0] tx_data_in;
    logic          tx_valid_in;
    logic          tx_ready_out;
    logic          rx_overflow_out;
    logic          busy_out;

    int            checks;
    int            failures;
    int            exp_ovf;
    int            ovf_seen;
    int            g_lat;
    logic [DW-1:0] exp_q [$];

    spi_slave_port #(
        .DATA_W      (DW),
        .FIFO_DEPTH  (DEPTH),
        .SYNC_STAGES (SS)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .sclk_in         (sclk_in),
        .cs_n_in         (cs_n_in),
        .mosi_in         (mosi_in),
        .miso_out        (miso_out),
        .miso_oe_out     (miso_oe_out),
        .rx_data_out     (rx_data_out),
        .rx_valid_out    (rx_valid_out),
        .rx_ready_in     (rx_ready_in),
        .tx_data_in      (tx_data_in),
        .tx_valid_in     (tx_valid_in),
        .tx_ready_out    (tx_ready_out),
        .rx_overflow_out (rx_overflow_out),
        .busy_out        (busy_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count overflow pulses as they appear.
    initial ovf_seen = 0;
    always @(negedge clk) if (rx_overflow_out === 1'b1) ovf_seen++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One byte as master; sclk high/low phases are 4 clk each.
    task automatic spi_byte(input logic [7:0] tx, input bit start, input bit stop,
                            output logic [7:0] rx);
        g_lat = 0;
        if (start) begin
            cs_n_in = 1'b0;
            wait_clks(4);
        end
        for (int i = 7; i >= 0; i--) begin
            mosi_in = tx[i];
            wait_clks(4);
            rx[i]   = miso_out;
            sclk_in = 1'b1;
            for (int k = 1; k <= 4; k++) begin
                @(negedge clk);
                if (i == 0 && g_lat == 0 && rx_valid_out === 1'b1) g_lat = k;
            end
            sclk_in = 1'b0;
            if (i == 0 && stop) cs_n_in = 1'b1;
        end
        if (exp_q.size() < DEPTH) exp_q.push_back(tx);
        else exp_ovf++;
        if (stop) wait_clks(6);
    endtask

    // Pop everything the model expects and compare in order.
    task automatic drain();
        while (exp_q.size() > 0) begin
            logic [7:0] e;
            int         t;
            e = exp_q.pop_front();
            t = 0;
            while (rx_valid_out !== 1'b1 && t < 20) begin
                @(negedge clk);
                t++;
            end
            checks++;
            if (rx_valid_out !== 1'b1) begin
                failures++;
                $display("FAIL rx_timeout: rx_valid_out=%b required 1 for byte %h", rx_valid_out, e);
            end else if (rx_data_out !== e) begin
                failures++;
                $display("FAIL rx_data: got %h required %h", rx_data_out, e);
            end
            rx_ready_in = 1'b1;
            @(negedge clk);
            rx_ready_in = 1'b0;
        end
        wait_clks(2);
        checks++;
        if (rx_valid_out !== 1'b0) begin
            failures++;
            $display("FAIL rx_empty_after_drain: rx_valid_out=%b required 0", rx_valid_out);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sclk_in = 1'b0; cs_n_in = 1'b1; mosi_in = 1'b0;
        rx_ready_in = 1'b0; tx_valid_in = 1'b0; tx_data_in = 8'h00;
        exp_ovf = 0;
        wait_clks(3);
        rst_n = 1'b1;
        wait_clks(4);
        checks++; if (miso_out !== 1'b0) begin failures++; $display("FAIL reset_miso: got %b required 0", miso_out); end
        checks++; if (miso_oe_out !== 1'b0) begin failures++; $display("FAIL reset_oe: got %b required 0", miso_oe_out); end
        checks++; if (rx_valid_out !== 1'b0) begin failures++; $display("FAIL reset_rx_valid: got %b required 0", rx_valid_out); end
        checks++; if (rx_data_out !== 8'h00) begin failures++; $display("FAIL reset_rx_data: got %h required 00", rx_data_out); end
        checks++; if (tx_ready_out !== 1'b1) begin failures++; $display("FAIL reset_tx_ready: got %b required 1", tx_ready_out); end
        checks++; if (rx_overflow_out !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %b required 0", rx_overflow_out); end
        checks++; if (busy_out !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b required 0", busy_out); end
    endtask

    task automatic test_basic();
        logic [7:0] rx;
        tx_data_in = 8'hA5; tx_valid_in = 1'b1;
        @(negedge clk);
        tx_valid_in = 1'b0;
        checks++; if (tx_ready_out !== 1'b0) begin failures++; $display("FAIL basic_tx_loaded: tx_ready=%b required 0", tx_ready_out); end
        spi_byte(8'h3C, 1'b1, 1'b1, rx);
        checks++; if (rx !== 8'hA5) begin failures++; $display("FAIL basic_miso: got %h required a5", rx); end
        checks++; if (g_lat != SS + 2) begin failures++; $display("FAIL basic_latency: got %0d required %0d", g_lat, SS + 2); end
        checks++; if (tx_ready_out !== 1'b1) begin failures++; $display("FAIL basic_tx_consumed: tx_ready=%b required 1", tx_ready_out); end
        drain();
    endtask

    task automatic test_no_tx();
        logic [7:0] rx;
        logic [7:0] e1;
        logic [7:0] e2;
`ifdef SPI_SLAVE_LOOPBACK_EN
        e1 = 8'h3C; e2 = 8'h81;
`else
        e1 = 8'h00; e2 = 8'h00;
`endif
        spi_byte(8'h81, 1'b1, 1'b1, rx);
        checks++; if (rx !== e1) begin failures++; $display("FAIL notx_frame1: got %h required %h", rx, e1); end
        spi_byte(8'h00, 1'b1, 1'b1, rx);
        checks++; if (rx !== e2) begin failures++; $display("FAIL notx_frame2: got %h required %h", rx, e2); end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [7:0] rx;
        int         ovf0;
        ovf0    = ovf_seen;
        exp_ovf = 0;
        for (int b = 1; b <= 5; b++) begin
            spi_byte(8'(b), b == 1, b == 5, rx);
        end
        checks++;
        if ((ovf_seen - ovf0) != exp_ovf || exp_ovf != 1) begin
            failures++;
            $display("FAIL b2b_overflow: pulses=%0d required %0d", ovf_seen - ovf0, exp_ovf);
        end
        drain();
    endtask

    task automatic test_partial();
        logic [7:0] rx;
        cs_n_in = 1'b0;
        wait_clks(4);
        for (int i = 0; i < 5; i++) begin
            mosi_in = 1'b1; wait_clks(4);
            sclk_in = 1'b1; wait_clks(4);
            sclk_in = 1'b0;
        end
        wait_clks(4);
        checks++; if (busy_out !== 1'b1 || miso_oe_out !== 1'b1) begin failures++; $display("FAIL partial_busy: busy=%b oe=%b required 1 1", busy_out, miso_oe_out); end
        cs_n_in = 1'b1;
        wait_clks(4);
        checks++; if (busy_out !== 1'b0 || miso_oe_out !== 1'b0) begin failures++; $display("FAIL partial_release: busy=%b oe=%b required 0 0", busy_out, miso_oe_out); end
        wait_clks(4);
        checks++; if (rx_valid_out !== 1'b0) begin failures++; $display("FAIL partial_no_push: rx_valid=%b required 0", rx_valid_out); end
        spi_byte(8'h42, 1'b1, 1'b1, rx);
        drain();
    endtask

    task automatic test_reset_midframe();
        logic [7:0]  rx;
        logic [13:0] obs;
        cs_n_in = 1'b0;
        wait_clks(4);
        for (int i = 0; i < 3; i++) begin
            mosi_in = i[0]; wait_clks(4);
            sclk_in = 1'b1; wait_clks(4);
            sclk_in = 1'b0;
        end
        tx_data_in = 8'h77; tx_valid_in = 1'b1;
        @(negedge clk);
        tx_valid_in = 1'b0;
        wait_clks(2);
        rst_n = 1'b0;
        #1;
        obs = {miso_out, miso_oe_out, busy_out, rx_valid_out, tx_ready_out, rx_overflow_out, rx_data_out};
        checks++;
        if (obs !== {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00}) begin
            failures++;
            $display("FAIL midreset_outputs: got %b required 00001000000000", obs);
        end
        cs_n_in = 1'b1;
        wait_clks(3);
        rst_n = 1'b1;
        wait_clks(4);
        spi_byte(8'h99, 1'b1, 1'b1, rx);
        checks++; if (rx !== 8'h00) begin failures++; $display("FAIL midreset_miso: got %h required 00", rx); end
        drain();
    endtask

    task automatic test_tx_collision();
        logic [7:0] rx;
        logic [7:0] e1;
`ifdef SPI_SLAVE_LOOPBACK_EN
        e1 = 8'h99;
`else
        e1 = 8'h00;
`endif
        cs_n_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tx_data_in = 8'h55; tx_valid_in = 1'b1;
        @(negedge clk);
        tx_valid_in = 1'b0;
        checks++; if (tx_ready_out !== 1'b0) begin failures++; $display("FAIL collide_stored: tx_ready=%b required 0", tx_ready_out); end
        spi_byte(8'h12, 1'b0, 1'b1, rx);
        checks++; if (rx !== e1) begin failures++; $display("FAIL collide_frame1: got %h required %h", rx, e1); end
        spi_byte(8'h34, 1'b1, 1'b1, rx);
        checks++; if (rx !== 8'h55) begin failures++; $display("FAIL collide_frame2: got %h required 55", rx); end
        checks++; if (tx_ready_out !== 1'b1) begin failures++; $display("FAIL collide_consumed: tx_ready=%b required 1", tx_ready_out); end
        drain();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_no_tx();
        test_back_to_back();
        test_partial();
        test_reset_midframe();
        test_tx_collision();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
